// File: rtl/tx_pkg.sv
// Shared definitions for the FT245 transmit arbiter: FSM states, header layout and source IDs.
package tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } tx_state_e;

    localparam int unsigned TX_DATA_WIDTH = 8;
    localparam int unsigned HDR_CONT_BIT  = TX_DATA_WIDTH - 1;
    localparam int unsigned BURST_CNT_W   = 16;

    localparam int unsigned SRC_TRIG = 0;
    localparam int unsigned SRC_CH1  = 1;
    localparam int unsigned SRC_CH2  = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index after last_ptr, wrapping.
module rr_pick #(
    parameter int unsigned SOURCES = 3,
    parameter int unsigned SRC_W   = $clog2(SOURCES)
) (
    input  logic [SOURCES-1:0] req,
    input  logic [SRC_W-1:0]   last_ptr,
    output logic               valid,
    output logic [SRC_W-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned off = 1; off <= SOURCES; off++) begin
            cand = (32'(last_ptr) + off) % SOURCES;
            if (!valid && req[SRC_W'(cand)]) begin
                valid = 1'b1;
                idx   = SRC_W'(cand);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Frame-level round-robin arbiter sharing the FT245 transmit stream among several sources.
// Each grant is prefixed by a header byte {cont, 0.., source id}; long frames split at MAX_BURST.
module tx_arbiter
    import tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TX_DATA_WIDTH,
    parameter int unsigned SOURCES    = SRC_CH2 + 1,
    parameter int unsigned MAX_BURST  = 256,
    parameter int unsigned SRC_W      = $clog2(SOURCES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SOURCES*DATA_WIDTH-1:0] src_data,
    input  logic [SOURCES-1:0]            src_rdy,
    input  logic [SOURCES-1:0]            src_eof,
    output logic [SOURCES-1:0]            src_ack,
    input  logic [SOURCES-1:0]            src_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_rdy,
    input  logic                          tx_ack,
    output logic                          busy,
    output logic [SRC_W-1:0]              grant
);

    if (DATA_WIDTH < SRC_W + 1) begin : g_hdr_width_check
        $error("tx_arbiter: DATA_WIDTH too narrow for header (cont bit + source id)");
    end
    if (MAX_BURST < 1 || MAX_BURST > 65535) begin : g_burst_range_check
        $error("tx_arbiter: MAX_BURST must be in 1..65535");
    end

    tx_state_e              state_q, state_d;
    logic [SRC_W-1:0]       grant_q, grant_d;
    logic [SRC_W-1:0]       last_ptr_q, last_ptr_d;
    logic [SOURCES-1:0]     cont_q, cont_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [SOURCES-1:0]    req;
    logic                  pick_valid;
    logic [SRC_W-1:0]      pick_idx;
    logic [DATA_WIDTH-1:0] hdr;
    logic [DATA_WIDTH-1:0] src_beat [SOURCES];
    logic                  beat_ok;
    logic [BURST_CNT_W:0]  cnt_inc;

    for (genvar i = 0; i < SOURCES; i++) begin : g_unpack
        assign src_beat[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // A source at end-of-frame has nothing to send, so it must not win arbitration.
    assign req = src_rdy & src_en & ~src_eof;

    rr_pick #(
        .SOURCES (SOURCES),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_comb begin
        hdr                 = '0;
        hdr[DATA_WIDTH-1]   = cont_q[grant_q];
        hdr[SRC_W-1:0]      = grant_q;
    end

    assign beat_ok = tx_ack & src_rdy[grant_q];
    assign cnt_inc = {1'b0, burst_cnt_q} + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_ptr_d  = last_ptr_q;
        cont_d      = cont_q;
        burst_cnt_d = burst_cnt_q;
        tx_rdy      = 1'b0;
        tx_data     = '0;
        src_ack     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    last_ptr_d = pick_idx;
                    state_d    = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_rdy  = 1'b1;
                tx_data = hdr;
                if (tx_ack) begin
                    burst_cnt_d = '0;
                    state_d     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // EOF wins over a simultaneous rdy: the frame is over, nothing is transferred.
                if (src_eof[grant_q]) begin
                    cont_d[grant_q] = 1'b0;
                    state_d         = ST_IDLE;
                end else begin
                    tx_rdy           = src_rdy[grant_q];
                    tx_data          = src_beat[grant_q];
                    src_ack[grant_q] = beat_ok;
                    if (beat_ok) begin
                        burst_cnt_d = cnt_inc[BURST_CNT_W-1:0];
                        if (cnt_inc == (BURST_CNT_W+1)'(MAX_BURST)) begin
                            cont_d[grant_q] = 1'b1;
                            state_d         = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            tx_rdy  = 1'b0;
            src_ack = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_ptr_q  <= SRC_W'(SOURCES - 1);
            cont_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_ptr_q  <= last_ptr_d;
            cont_q      <= cont_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed scoreboard bench for tx_arbiter: one default instance and one with MAX_BURST=4.
module tb_tx_arbiter;
    import tx_pkg::*;

    localparam int unsigned NS = 3;

    typedef struct {
        logic [7:0] d;
        int         src;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS*8-1:0] src_data;
    logic [NS-1:0] src_rdy, src_eof, src_en;
    logic          tx_ack;
    logic          sel;
    logic          toggle;

    logic [NS-1:0] d_src_ack, d4_src_ack;
    logic [7:0]    d_tx_data, d4_tx_data;
    logic          d_tx_rdy, d4_tx_rdy, d_busy, d4_busy;
    logic [1:0]    d_grant, d4_grant;

    logic [NS-1:0] m_src_ack;
    logic [7:0]    m_tx_data;
    logic          m_tx_rdy, m_busy;
    logic [1:0]    m_grant;

    logic [NS-1:0] rdy_main, rdy_b4;
    assign rdy_main = sel ? '0 : src_rdy;
    assign rdy_b4   = sel ? src_rdy : '0;

    assign m_src_ack = sel ? d4_src_ack : d_src_ack;
    assign m_tx_data = sel ? d4_tx_data : d_tx_data;
    assign m_tx_rdy  = sel ? d4_tx_rdy  : d_tx_rdy;
    assign m_busy    = sel ? d4_busy    : d_busy;
    assign m_grant   = sel ? d4_grant   : d_grant;

    tx_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .src_data (src_data),
        .src_rdy  (rdy_main),
        .src_eof  (src_eof),
        .src_ack  (d_src_ack),
        .src_en   (src_en),
        .tx_data  (d_tx_data),
        .tx_rdy   (d_tx_rdy),
        .tx_ack   (tx_ack),
        .busy     (d_busy),
        .grant    (d_grant)
    );

    tx_arbiter #(
        .MAX_BURST (4)
    ) dut4 (
        .clk      (clk),
        .rst      (rst),
        .src_data (src_data),
        .src_rdy  (rdy_b4),
        .src_eof  (src_eof),
        .src_ack  (d4_src_ack),
        .src_en   (src_en),
        .tx_data  (d4_tx_data),
        .tx_rdy   (d4_tx_rdy),
        .tx_ack   (tx_ack),
        .busy     (d4_busy),
        .grant    (d4_grant)
    );

    always #5 clk = ~clk;

    exp_t       sb [$];
    logic [7:0] srcq [NS][$];
    bit         eof_pend [NS];
    int         nvec  = 0;
    int         nfail = 0;
    logic       s_busy, s_rdy;
    logic [NS-1:0] acked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NS; i++) begin
            src_data[i*8 +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
            src_rdy[i]         = (srcq[i].size() > 0);
            src_eof[i]         = eof_pend[i] && (srcq[i].size() == 0);
        end
    endtask

    task automatic load_src(input int s, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) srcq[s].push_back(base + 8'(k));
        eof_pend[s] = 1'b1;
        drive_src();
    endtask

    task automatic exp_hdr(input logic [7:0] h);
        exp_t e;
        e.d = h; e.src = -1;
        sb.push_back(e);
    endtask

    task automatic exp_beats(input int s, input logic [7:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.d = base + 8'(k); e.src = s;
            sb.push_back(e);
        end
    endtask

    // One clock: check outputs at negedge against the scoreboard, then let sources pop.
    task automatic cycle();
        logic [NS-1:0] exp_ack;
        @(negedge clk);
        s_busy  = m_busy;
        s_rdy   = m_tx_rdy;
        exp_ack = '0;
        if (m_tx_rdy) begin
            if (sb.size() == 0) begin
                chk("tx_rdy_unexpected", {31'd0, m_tx_rdy}, 32'd0);
            end else begin
                chk("tx_data", {24'd0, m_tx_data}, {24'd0, sb[0].d});
                if (tx_ack) begin
                    if (sb[0].src >= 0) exp_ack = NS'(1 << sb[0].src);
                    void'(sb.pop_front());
                end
            end
        end
        chk("src_ack", {29'd0, m_src_ack}, {29'd0, exp_ack});
        acked = m_src_ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (acked[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (toggle) tx_ack = ~tx_ack;
        drive_src();
    endtask

    task automatic run(input string tag, input int bound);
        int n = 0;
        while (sb.size() > 0 && n < bound) begin
            cycle();
            n++;
        end
        chk({tag, "_drain"}, sb.size(), 32'd0);
    endtask

    task automatic end_frame(input string tag);
        cycle();
        chk({tag, "_busy_at_eof"}, {31'd0, s_busy}, 32'd1);
        chk({tag, "_rdy_at_eof"}, {31'd0, s_rdy}, 32'd0);
        cycle();
        chk({tag, "_busy_after_eof"}, {31'd0, s_busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        sel    = 1'b0;
        toggle = 1'b0;
        tx_ack = 1'b1;
        src_en = '1;
        for (int i = 0; i < NS; i++) eof_pend[i] = 1'b0;
        drive_src();
        do_reset();

        @(negedge clk);
        chk("rst_tx_rdy", {31'd0, m_tx_rdy}, 32'd0);
        chk("rst_tx_data", {24'd0, m_tx_data}, 32'd0);
        chk("rst_src_ack", {29'd0, m_src_ack}, 32'd0);
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        chk("rst_grant", {30'd0, m_grant}, 32'd0);
        @(posedge clk);
        #1;

        // Single source on ch1
        load_src(SRC_CH1, 8'h11, 4);
        exp_hdr(8'h01); exp_beats(SRC_CH1, 8'h11, 4);
        run("single", 40);
        end_frame("single");

        // Simultaneous requests right after reset: source 0 first
        do_reset();
        load_src(SRC_TRIG, 8'h21, 2);
        load_src(SRC_CH1, 8'h31, 2);
        load_src(SRC_CH2, 8'h41, 2);
        exp_hdr(8'h00); exp_beats(SRC_TRIG, 8'h21, 2);
        exp_hdr(8'h01); exp_beats(SRC_CH1, 8'h31, 2);
        exp_hdr(8'h02); exp_beats(SRC_CH2, 8'h41, 2);
        run("all3", 60);
        end_frame("all3");

        // Fairness: ch1 granted alone, then everyone requests
        load_src(SRC_CH1, 8'h51, 1);
        exp_hdr(8'h01); exp_beats(SRC_CH1, 8'h51, 1);
        run("rr_pre", 20);
        end_frame("rr_pre");
        load_src(SRC_TRIG, 8'h61, 1);
        load_src(SRC_CH1, 8'h62, 1);
        load_src(SRC_CH2, 8'h63, 1);
        exp_hdr(8'h02); exp_beats(SRC_CH2, 8'h63, 1);
        exp_hdr(8'h00); exp_beats(SRC_TRIG, 8'h61, 1);
        exp_hdr(8'h01); exp_beats(SRC_CH1, 8'h62, 1);
        run("rr", 60);
        end_frame("rr");
        chk("grant_last", {30'd0, m_grant}, 32'd1);

        // Backpressure: tx_ack toggles every cycle
        toggle = 1'b1;
        load_src(SRC_CH2, 8'hA1, 4);
        exp_hdr(8'h02); exp_beats(SRC_CH2, 8'hA1, 4);
        run("bp", 60);
        end_frame("bp");
        toggle = 1'b0;
        tx_ack = 1'b1;

        // Enable mask: a disabled trig waits until re-enabled
        src_en = 3'b110;
        load_src(SRC_TRIG, 8'h71, 1);
        load_src(SRC_CH1, 8'h72, 1);
        exp_hdr(8'h01); exp_beats(SRC_CH1, 8'h72, 1);
        run("en_mask", 30);
        end_frame("en_mask");
        exp_hdr(8'h00); exp_beats(SRC_TRIG, 8'h71, 1);
        src_en = 3'b111;
        run("en_mask_re", 30);
        end_frame("en_mask_re");

        // Reset mid-payload on ch1
        load_src(SRC_CH1, 8'hC1, 6);
        exp_hdr(8'h01); exp_beats(SRC_CH1, 8'hC1, 6);
        begin
            int n = 0;
            while (sb.size() > 4 && n < 30) begin
                cycle();
                n++;
            end
        end
        chk("midrst_progress", sb.size(), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx_rdy_forced", {31'd0, m_tx_rdy}, 32'd0);
        chk("midrst_src_ack_forced", {29'd0, m_src_ack}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx_rdy", {31'd0, m_tx_rdy}, 32'd0);
        chk("midrst_busy", {31'd0, m_busy}, 32'd0);
        sb.delete();
        exp_hdr(8'h01); exp_beats(SRC_CH1, 8'hC3, 4);
        run("midrst_regrant", 40);
        end_frame("midrst_regrant");

        // Burst limit on the MAX_BURST=4 instance
        sel = 1'b1;
        drive_src();
        load_src(SRC_CH2, 8'hD0, 10);
        exp_hdr(8'h02); exp_beats(SRC_CH2, 8'hD0, 4);
        exp_hdr(8'h82); exp_beats(SRC_CH2, 8'hD4, 4);
        exp_hdr(8'h82); exp_beats(SRC_CH2, 8'hD8, 2);
        run("burst", 80);
        end_frame("burst");
        load_src(SRC_CH2, 8'hE0, 1);
        exp_hdr(8'h02); exp_beats(SRC_CH2, 8'hE0, 1);
        run("burst_cont_clr", 20);
        end_frame("burst_cont_clr");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
